multicycle_controller: RTL

//  Multi-cycle successor of the single-cycle opcode decoder. Accepts one instruction
//  per handshake, holds it in an instruction register and sequences ALU, memory,

---
 rtl/ctrl_pkg.sv | 24 ++
 rtl/multicycle_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle controller: instruction type field encodings
// and the sequencer state encoding.
package ctrl_pkg;

  localparam logic [1:0] TYPE_REG = 2'b00;
  localparam logic [1:0] TYPE_IMM = 2'b01;
  localparam logic [1:0] TYPE_MEM = 2'b10;
  localparam logic [1:0] TYPE_BR  = 2'b11;

  typedef enum logic [1:0] {
    IT_REG = TYPE_REG,
    IT_IMM = TYPE_IMM,
    IT_MEM = TYPE_MEM,
    IT_BR  = TYPE_BR
  } instr_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MEM  = 2'b10,
    ST_WB   = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: latches one opcode per handshake and walks it
// through EXEC / MEM / WB, with memory timeout, illegal-branch trap and retire count.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OPC_W    = 6,
  parameter int ALU_OP_W = 4,
  parameter int BR_OPS   = 4,
  parameter int MEM_TMO  = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPC_W-1:0]    instruction,
  input  logic                mem_ack,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                sel_alu_reg,
  output logic                sel_alu_const,
  output logic                mem_req,
  output logic                mem_we,
  output logic                reg_write,
  output logic                pc_write,
  output logic                illegal,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    retired
);

  localparam int SUB_W = OPC_W - 2;
  localparam int TMO_W = $clog2(MEM_TMO + 1);

  generate
    if (ALU_OP_W < SUB_W) begin : g_bad_alu_w
      $error("ALU_OP_W must be >= OPC_W-2");
    end
  endgenerate

  ctrl_state_e      state_q, state_d;
  logic [OPC_W-1:0] ir_q, ir_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             store_done_q, store_done_d;
  logic             tmo_pulse_q, tmo_pulse_d;

  instr_type_e      ir_type_s;
  logic [SUB_W-1:0] ir_sub_s;
  logic             br_legal_s;

  assign ir_type_s  = instr_type_e'(ir_q[OPC_W-1:OPC_W-2]);
  assign ir_sub_s   = ir_q[SUB_W-1:0];
  assign br_legal_s = (int'(ir_sub_s) < BR_OPS);

  // State, instruction register, timeout counter and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ir_q         <= {OPC_W{1'b0}};
      tmo_cnt_q    <= {TMO_W{1'b0}};
      retired_q    <= {CNT_W{1'b0}};
      store_done_q <= 1'b0;
      tmo_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      tmo_cnt_q    <= tmo_cnt_d;
      retired_q    <= retired_d;
      store_done_q <= store_done_d;
      tmo_pulse_q  <= tmo_pulse_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    tmo_cnt_d    = tmo_cnt_q;
    retired_d    = retired_q;
    store_done_d = 1'b0;
    tmo_pulse_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ir_d    = instruction;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (ir_type_s)
          IT_REG:  state_d = ST_WB;
          IT_IMM:  state_d = ST_WB;
          IT_MEM:  state_d = ST_MEM;
          IT_BR: begin
            state_d = ST_IDLE;
            if (br_legal_s) begin
              retired_d = retired_q + CNT_W'(1);
            end else begin
              retired_d = retired_q;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          tmo_cnt_d = {TMO_W{1'b0}};
          if (ir_q[0]) begin
            store_done_d = 1'b1;
            retired_d    = retired_q + CNT_W'(1);
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_cnt_q == TMO_W'(MEM_TMO - 1)) begin
          tmo_cnt_d   = {TMO_W{1'b0}};
          tmo_pulse_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from registered state, IR and completion pulses.
  always_comb begin
    instr_ready   = 1'b0;
    alu_op        = {ALU_OP_W{1'b0}};
    sel_alu_reg   = 1'b0;
    sel_alu_const = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    reg_write     = 1'b0;
    pc_write      = store_done_q;
    illegal       = 1'b0;
    case (state_q)
      ST_IDLE: instr_ready = 1'b1;
      ST_EXEC: begin
        alu_op = ALU_OP_W'(ir_sub_s);
        case (ir_type_s)
          IT_REG:  sel_alu_reg   = 1'b1;
          IT_IMM:  sel_alu_const = 1'b1;
          IT_MEM:  sel_alu_const = 1'b1;
          IT_BR: begin
            if (br_legal_s) begin
              pc_write = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          default: sel_alu_reg = 1'b0;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = ir_q[0];
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      default: instr_ready = 1'b0;
    endcase
  end

  assign mem_timeout = tmo_pulse_q;
  assign retired     = retired_q;

endmodule
